// File: rtl/int_stim_gen_if.sv
// Config/control/status bundle for the interrupt stimulus generator.
// The bench drives the master side; the generator takes the slave side.
interface int_stim_gen_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic              run;
  logic              cnt_clr;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [1:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] int_n;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [NUM_CH-1:0] ch_busy;

  modport master (
    output run, cnt_clr, cfg_we, cfg_ch,
    output cfg_addr, cfg_wdata, ack,
    input  int_n, cycle_cnt, ch_busy
  );

  modport slave (
    input  run, cnt_clr, cfg_we, cfg_ch,
    input  cfg_addr, cfg_wdata, ack,
    output int_n, cycle_cnt, ch_busy
  );
endinterface

// File: rtl/int_stim_gen.sv
// Programmable active-low interrupt stimulus generator.
// One shared cycle counter; one window/periodic/latched FSM per channel.
module int_stim_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic          clk_ph1,
  input  logic          rst,
  int_stim_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACTIVE, S_GAP, S_DONE
  } state_t;

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_WIN = 2'd1;
  localparam logic [1:0] M_LAT = 2'd3;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  start_q  [NUM_CH];
  logic [CNT_W-1:0]  width_q  [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [1:0]        mode_q   [NUM_CH];
  logic [CNT_W-1:0]  w_eff    [NUM_CH];
  logic [CNT_W-1:0]  p_eff    [NUM_CH];
  logic [CNT_W-1:0]  wcnt_q   [NUM_CH];
  logic [CNT_W-1:0]  wcnt_d   [NUM_CH];
  logic [CNT_W-1:0]  gcnt_q   [NUM_CH];
  logic [CNT_W-1:0]  gcnt_d   [NUM_CH];
  state_t            state_q  [NUM_CH];
  state_t            state_d  [NUM_CH];
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] int_n_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g]    = bus.cfg_we && (bus.cfg_ch == 3'(g));
    assign w_eff[g] = (width_q[g] == '0) ? ONE : width_q[g];
    assign p_eff[g] = (period_q[g] == '0) ? ONE : period_q[g];
    assign busy[g]  = (state_q[g] == S_WAIT) ||
                      (state_q[g] == S_ACTIVE) ||
                      (state_q[g] == S_GAP);
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (bus.run) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        start_q[i]  <= '0;
        width_q[i]  <= '0;
        period_q[i] <= '0;
        mode_q[i]   <= M_OFF;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr[i]) begin
          unique case (bus.cfg_addr)
            2'd0:    start_q[i]  <= bus.cfg_wdata;
            2'd1:    width_q[i]  <= bus.cfg_wdata;
            2'd2:    period_q[i] <= bus.cfg_wdata;
            default: mode_q[i]   <= bus.cfg_wdata[1:0];
          endcase
        end
      end
    end
  end

  // A config write always parks the channel, overriding ack and timers.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      wcnt_d[i]  = wcnt_q[i];
      gcnt_d[i]  = gcnt_q[i];
      if (wr[i]) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (mode_q[i] != M_OFF) state_d[i] = S_WAIT;
          end
          S_WAIT: begin
            if (bus.run && cnt_q == start_q[i]) begin
              state_d[i] = S_ACTIVE;
              wcnt_d[i]  = w_eff[i];
            end
          end
          S_ACTIVE: begin
            if (mode_q[i] == M_LAT) begin
              if (bus.ack[i]) begin
                state_d[i] = S_GAP;
                gcnt_d[i]  = p_eff[i];
              end
            end else if (bus.run) begin
              if (wcnt_q[i] == ONE) begin
                if (mode_q[i] == M_WIN) begin
                  state_d[i] = S_DONE;
                end else begin
                  state_d[i] = S_GAP;
                  gcnt_d[i]  = p_eff[i];
                end
              end else begin
                wcnt_d[i] = wcnt_q[i] - ONE;
              end
            end
          end
          S_GAP: begin
            if (bus.run) begin
              if (gcnt_q[i] == ONE) begin
                state_d[i] = S_ACTIVE;
                wcnt_d[i]  = w_eff[i];
              end else begin
                gcnt_d[i] = gcnt_q[i] - ONE;
              end
            end
          end
          default: state_d[i] = state_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        wcnt_q[i]  <= '0;
        gcnt_q[i]  <= '0;
      end
      int_n_q <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        wcnt_q[i]  <= wcnt_d[i];
        gcnt_q[i]  <= gcnt_d[i];
        int_n_q[i] <= (state_d[i] != S_ACTIVE);
      end
    end
  end

  assign bus.int_n     = int_n_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.ch_busy   = busy;

endmodule

// File: tb/tb_int_stim_gen.sv
// Randomized self-checking bench for int_stim_gen.
// Expected waveforms come from closed-form pulse arithmetic.
module tb_int_stim_gen;

  logic clk_ph1 = 1'b0;
  logic rst;

  always #5 clk_ph1 = ~clk_ph1;

  int_stim_gen_if #(.NUM_CH(2), .CNT_W(16)) bus ();
  int_stim_gen_if #(.NUM_CH(1), .CNT_W(4))  bus4 ();

  int_stim_gen #(.NUM_CH(2), .CNT_W(16)) dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (bus)
  );

  int_stim_gen #(.NUM_CH(1), .CNT_W(4)) dut4 (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (bus4)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  function automatic int at_least_1(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expected "line is low" after an edge that leaves the counter at c.
  function automatic bit exp_low(int mode, int c, int s,
                                 int w, int p, int ack_at);
    int we = at_least_1(w);
    int pe = at_least_1(p);
    if (c <= s) return 1'b0;
    case (mode)
      1:       return c <= s + we;
      2:       return ((c - s - 1) % (we + pe)) < we;
      3:       return (c <= ack_at) || (c > ack_at + pe);
      default: return 1'b0;
    endcase
  endfunction

  task automatic cfg_write(input int ch, input int addr, input int data);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 3'(ch);
    bus.cfg_addr  = 2'(addr);
    bus.cfg_wdata = 16'(data);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Program one channel, silence the other, zero the counter, start running.
  task automatic setup(input int ch, input int mode, input int s,
                       input int w, input int p);
    bus.run = 1'b0;
    bus.ack = '0;
    cfg_write(0, 3, 0);
    cfg_write(1, 3, 0);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    cfg_write(ch, 0, s);
    cfg_write(ch, 1, w);
    cfg_write(ch, 2, p);
    cfg_write(ch, 3, mode);
    tick();
    bus.run = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 0; bus.cnt_clr = 0; bus.cfg_we = 0; bus.cfg_ch = 0;
    bus.cfg_addr = 0; bus.cfg_wdata = 0; bus.ack = 0;
    bus4.run = 0; bus4.cnt_clr = 0; bus4.cfg_we = 0; bus4.cfg_ch = 0;
    bus4.cfg_addr = 0; bus4.cfg_wdata = 0; bus4.ack = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (bus.int_n !== 2'b11)
      $display("FAIL reset_int_n: got %b want 11", bus.int_n);
    else n_pass++;
    n_chk++;
    if (bus.cycle_cnt !== 16'd0)
      $display("FAIL reset_cnt: got %0d want 0", bus.cycle_cnt);
    else n_pass++;
    n_chk++;
    if (bus.ch_busy !== 2'b00)
      $display("FAIL reset_busy: got %b want 00", bus.ch_busy);
    else n_pass++;
    n_chk++;
    if (bus4.int_n !== 1'b1)
      $display("FAIL reset_int_n4: got %b want 1", bus4.int_n);
    else n_pass++;
  endtask

  task automatic test_window();
    int s, w, n;
    bit lo;
    for (int it = 0; it < 5; it++) begin
      s = (it == 0) ? 8 : $urandom_range(0, 15);
      w = (it == 0) ? 12 : $urandom_range(0, 8);
      n = s + at_least_1(w) + 4;
      setup(0, 1, s, w, 0);
      for (int k = 1; k <= n; k++) begin
        tick();
        lo = exp_low(1, k, s, w, 0, 0);
        n_chk++;
        if (bus.cycle_cnt !== 16'(k))
          $display("FAIL window_cnt: got %0d want %0d",
                   bus.cycle_cnt, k);
        else n_pass++;
        n_chk++;
        if (bus.int_n !== {1'b1, ~lo})
          $display("FAIL window_int_n s=%0d w=%0d c=%0d: got %b want %b",
                   s, w, k, bus.int_n, {1'b1, ~lo});
        else n_pass++;
      end
      n_chk++;
      if (bus.ch_busy[0] !== 1'b0)
        $display("FAIL window_busy_done: got %b want 0", bus.ch_busy[0]);
      else n_pass++;
    end
  endtask

  task automatic test_periodic();
    int s, w, p;
    bit lo;
    for (int it = 0; it < 4; it++) begin
      s = (it == 0) ? 4 : $urandom_range(0, 10);
      w = (it == 0) ? 2 : $urandom_range(0, 4);
      p = (it == 0) ? 3 : $urandom_range(0, 4);
      setup(1, 2, s, w, p);
      for (int k = 1; k <= s + 30; k++) begin
        tick();
        lo = exp_low(2, k, s, w, p, 0);
        n_chk++;
        if (bus.int_n !== {~lo, 1'b1})
          $display("FAIL periodic_int_n s=%0d w=%0d p=%0d c=%0d: got %b want %b",
                   s, w, p, k, bus.int_n, {~lo, 1'b1});
        else n_pass++;
      end
      n_chk++;
      if (bus.ch_busy[1] !== 1'b1)
        $display("FAIL periodic_busy: got %b want 1", bus.ch_busy[1]);
      else n_pass++;
    end
  endtask

  task automatic test_latched();
    int s, p, a, prev;
    bit lo;
    for (int it = 0; it < 4; it++) begin
      s = (it == 0) ? 10 : $urandom_range(0, 10);
      p = (it == 0) ? 5 : $urandom_range(0, 5);
      a = (it == 0) ? 20 : s + $urandom_range(1, 8);
      setup(0, 3, s, $urandom_range(0, 3), p);
      prev = 0;
      for (int k = 1; k <= a + at_least_1(p) + 6; k++) begin
        bus.ack = (prev == a) ? 2'b01 : 2'b00;
        tick();
        prev = k;
        lo = exp_low(3, k, s, 0, p, a);
        n_chk++;
        if (bus.int_n[0] !== ~lo)
          $display("FAIL latched_int_n s=%0d p=%0d a=%0d c=%0d: got %b want %b",
                   s, p, a, k, bus.int_n[0], ~lo);
        else n_pass++;
      end
      bus.ack = '0;
    end
  endtask

  task automatic test_rewrite();
    setup(0, 1, 5, 10, 0);
    repeat (8) tick();
    n_chk++;
    if (bus.int_n[0] !== 1'b0)
      $display("FAIL rewrite_pre: got %b want 0", bus.int_n[0]);
    else n_pass++;
    cfg_write(0, 1, 3);
    n_chk++;
    if (bus.int_n[0] !== 1'b1)
      $display("FAIL rewrite_drop: got %b want 1", bus.int_n[0]);
    else n_pass++;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_chk++;
      if (bus.int_n !== 2'b11)
        $display("FAIL rewrite_quiet: got %b want 11", bus.int_n);
      else n_pass++;
    end
    n_chk++;
    if (bus.ch_busy[0] !== 1'b1)
      $display("FAIL rewrite_wait_busy: got %b want 1", bus.ch_busy[0]);
    else n_pass++;
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_chk++;
    if (bus.cycle_cnt !== 16'd0)
      $display("FAIL rewrite_clr: got %0d want 0", bus.cycle_cnt);
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if (bus.int_n[0] !== ~exp_low(1, k, 5, 3, 0, 0))
        $display("FAIL rewrite_refire c=%0d: got %b want %b",
                 k, bus.int_n[0], ~exp_low(1, k, 5, 3, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_write_ack();
    setup(0, 3, 2, 1, 4);
    repeat (5) tick();
    n_chk++;
    if (bus.int_n[0] !== 1'b0)
      $display("FAIL wack_pre: got %b want 0", bus.int_n[0]);
    else n_pass++;
    bus.ack = 2'b01;
    cfg_write(0, 2, 4);
    bus.ack = 2'b00;
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (bus.int_n[0] !== 1'b1)
        $display("FAIL wack_write_wins k=%0d: got %b want 1",
                 k, bus.int_n[0]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_clear_match();
    setup(1, 1, 7, 2, 0);
    repeat (7) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_chk++;
    if (bus.cycle_cnt !== 16'd0)
      $display("FAIL clrmatch_cnt: got %0d want 0", bus.cycle_cnt);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (bus.int_n[1] !== (k >= 2))
        $display("FAIL clrmatch_int_n k=%0d: got %b want %b",
                 k, bus.int_n[1], (k >= 2));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_run_gate();
    int c = 0;
    int rem = 0;
    bit matched = 0;
    bit r;
    setup(0, 1, 3, 5, 0);
    for (int k = 0; k < 50; k++) begin
      r = 1'($urandom_range(0, 1));
      bus.run = r;
      bus.ack = {1'b0, 1'($urandom_range(0, 1))};
      tick();
      if (r) begin
        if (!matched && c == 3) begin
          matched = 1;
          rem = 5;
        end else if (matched && rem > 0) begin
          rem--;
        end
        c++;
      end
      n_chk++;
      if (bus.cycle_cnt !== 16'(c))
        $display("FAIL gate_cnt: got %0d want %0d", bus.cycle_cnt, c);
      else n_pass++;
      n_chk++;
      if (bus.int_n[0] !== (rem == 0))
        $display("FAIL gate_int_n k=%0d: got %b want %b",
                 k, bus.int_n[0], (rem == 0));
      else n_pass++;
    end
    bus.ack = '0;
    bus.run = 1'b1;
  endtask

  task automatic test_wrap();
    bit lo;
    bus4.run = 1'b0;
    bus4.cnt_clr = 1'b1;
    tick();
    bus4.cnt_clr = 1'b0;
    bus4.cfg_we = 1'b1;
    bus4.cfg_ch = 3'd0;
    bus4.cfg_addr = 2'd0; bus4.cfg_wdata = 4'd14; tick();
    bus4.cfg_addr = 2'd1; bus4.cfg_wdata = 4'd4;  tick();
    bus4.cfg_addr = 2'd3; bus4.cfg_wdata = 4'd1;  tick();
    bus4.cfg_we = 1'b0;
    tick();
    bus4.run = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      lo = (k >= 15) && (k <= 18);
      n_chk++;
      if (bus4.cycle_cnt !== 4'(k % 16))
        $display("FAIL wrap_cnt: got %0d want %0d",
                 bus4.cycle_cnt, k % 16);
      else n_pass++;
      n_chk++;
      if (bus4.int_n !== ~lo)
        $display("FAIL wrap_int_n k=%0d: got %b want %b",
                 k, bus4.int_n, ~lo);
      else n_pass++;
    end
    bus4.cnt_clr = 1'b1;
    tick();
    bus4.cnt_clr = 1'b0;
    n_chk++;
    if (bus4.cycle_cnt !== 4'd0)
      $display("FAIL wrap_clr_run: got %0d want 0", bus4.cycle_cnt);
    else n_pass++;
    bus4.run = 1'b0;
  endtask

  task automatic test_reset_mid();
    setup(0, 1, 2, 20, 0);
    repeat (5) tick();
    n_chk++;
    if (bus.int_n[0] !== 1'b0)
      $display("FAIL rstmid_pre: got %b want 0", bus.int_n[0]);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.int_n !== 2'b11)
      $display("FAIL rstmid_async_int_n: got %b want 11", bus.int_n);
    else n_pass++;
    n_chk++;
    if (bus.cycle_cnt !== 16'd0)
      $display("FAIL rstmid_cnt: got %0d want 0", bus.cycle_cnt);
    else n_pass++;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_chk++;
      if (bus.int_n !== 2'b11 || bus.ch_busy !== 2'b00)
        $display("FAIL rstmid_off k=%0d: got int_n=%b busy=%b want 11/00",
                 k, bus.int_n, bus.ch_busy);
      else n_pass++;
    end
    n_chk++;
    if (bus.cycle_cnt !== 16'd25)
      $display("FAIL rstmid_count: got %0d want 25", bus.cycle_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_window();
    test_periodic();
    test_latched();
    test_rewrite();
    test_write_ack();
    test_clear_match();
    test_run_gate();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
